// File: rtl/mazesolver_ram_reader_if.sv
// rtl/mazesolver_ram_reader_if.sv - control, Avalon-MM read and stream signals of the RAM reader
// Purpose: bundles the reader's control handshake, the RAM read-master bus and
//   the output stream into one interface.
// Modports:
//   master - the reader: drives busy/done, m_* strobes/address, st_data/st_valid/st_last
//   slave  - the environment: drives start/abort/base_addr/word_count, m_readdata, st_ready
interface mazesolver_ram_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic [3:0]        m_byteenable;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;

  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_last;
  logic              st_ready;

  modport master (
    input  start, abort, base_addr, word_count, m_readdata, st_ready,
    output busy, done, m_address, m_chipselect, m_write, m_byteenable, m_clken,
           st_data, st_valid, st_last
  );

  modport slave (
    output start, abort, base_addr, word_count, m_readdata, st_ready,
    input  busy, done, m_address, m_chipselect, m_write, m_byteenable, m_clken,
           st_data, st_valid, st_last
  );
endinterface

// File: rtl/mazesolver_ram_reader.sv
// rtl/mazesolver_ram_reader.sv - credit-limited RAM read master feeding a valid/ready stream
// Purpose: on start, reads word_count consecutive words from base_addr of a
//   single-port RAM with 1-cycle read latency and delivers them in order on a
//   stream through a small FIFO that absorbs downstream backpressure.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high
//   bus   - mazesolver_ram_reader_if.master (control, RAM read bus, output stream)
module mazesolver_ram_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  mazesolver_ram_reader_if.master   bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   recv_q, recv_d;
  logic              cs_q, cs_d;
  logic              inflight_q, inflight_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    fcount_q, fcount_d;

  logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;

  logic push, push_last, pop, pop_last, fifo_nonempty;

  assign fifo_nonempty = (fcount_q != '0);

  always_comb begin
    // A read issued last cycle returns its data now; it is pushed at this edge.
    push      = inflight_q;
    push_last = (recv_q == count_q - (ADDR_W+1)'(1));
    pop       = fifo_nonempty && bus.st_ready;
    pop_last  = pop && fifo_last_q[rd_ptr_q];

    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    issued_d = issued_q + (ADDR_W+1)'(cs_q);
    recv_d   = recv_q + (ADDR_W+1)'(push);
    fcount_d = fcount_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.word_count != '0) begin
            state_d  = RUN;
            base_d   = bus.base_addr;
            count_d  = bus.word_count;
            busy_d   = 1'b1;
            issued_d = '0;
            recv_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (cs_q && (issued_d == count_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobe is registered, so evaluate the issue rule on next-cycle values:
    // next in-flight is this cycle's strobe, next occupancy is fcount_d.
    inflight_d = cs_q;
    cs_d = (state_d == RUN) && (issued_d < count_d) &&
           (((PTR_W+2)'(fcount_d) + (PTR_W+2)'(inflight_d)) < DEPTH_C);
    addr_d = base_d + issued_d[ADDR_W-1:0];

    if (bus.abort) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      cs_d       = 1'b0;
      inflight_d = 1'b0;
      fcount_d   = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      addr_d     = addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      recv_q     <= '0;
      cs_q       <= 1'b0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      recv_q     <= recv_d;
      cs_q       <= cs_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcount_q   <= fcount_d;
    end
  end

  // Storage needs no reset: entries are only visible while fcount_q covers them.
  always_ff @(posedge clk) begin
    if (push && !bus.abort) begin
      fifo_data_q[wr_ptr_q] <= bus.m_readdata;
      fifo_last_q[wr_ptr_q] <= push_last;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.m_address    = addr_q;
  assign bus.m_chipselect = cs_q;
  assign bus.m_write      = 1'b0;
  assign bus.m_byteenable = 4'hF;
  assign bus.m_clken      = 1'b1;
  assign bus.st_valid     = fifo_nonempty;
  assign bus.st_data      = fifo_data_q[rd_ptr_q];
  assign bus.st_last      = fifo_nonempty && fifo_last_q[rd_ptr_q];
endmodule

// File: tb/tb_mazesolver_ram_reader.sv
// tb/tb_mazesolver_ram_reader.sv - directed self-checking bench for mazesolver_ram_reader
module tb_mazesolver_ram_reader;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mazesolver_ram_reader_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  mazesolver_ram_reader #(.ADDR_W(10), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ram_val(input logic [9:0] a);
    return {6'h2A, a, 6'h15, ~a};
  endfunction

  // RAM model: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.m_chipselect === 1'b1) bus.m_readdata <= ram_val(bus.m_address);
  end

  // mode 0: ready=1, mode 1: random ready, mode 2: ready=0 for 20 cycles then 1
  task automatic run_xfer(input logic [9:0] base, input int cnt, input int mode, input int abort_beat);
    int beats = 0;
    int issued = 0;
    int cyc = 0;
    int spurious = 0;
    int post_abort_cs = 0;
    int first_cs = -1;
    int last_cs = -1;
    int first_beat = -1;
    int budget = cnt * 8 + 100;
    bit last_seen = 1'b0;
    bit finished = 1'b0;
    logic [9:0] a;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = base; bus.word_count = 11'(cnt);
    @(negedge clk);
    bus.start = 1'b0; bus.base_addr = 10'h2AA; bus.word_count = 11'd5;
    check("busy_after_start", bus.busy, 1'b1);
    while (!finished && cyc < budget) begin
      if (last_seen) begin
        check("done_pulse", bus.done, 1'b1);
        check("busy_cleared", bus.busy, 1'b0);
        finished = 1'b1;
      end else begin
        if (bus.done === 1'b1) spurious++;
        case (mode)
          0:       bus.st_ready = 1'b1;
          1:       bus.st_ready = 1'($urandom_range(0, 1));
          default: bus.st_ready = (cyc >= 20);
        endcase
        if (bus.m_chipselect === 1'b1) begin
          a = base + 10'(issued);
          check("m_address", bus.m_address, a);
          if (first_cs < 0) first_cs = cyc;
          last_cs = cyc;
          issued++;
        end
        if (mode == 2 && cyc == 19) begin
          check("stall_reads", issued, 4);
          check("stall_cs_low", bus.m_chipselect, 1'b0);
        end
        if (bus.st_valid === 1'b1 && bus.st_ready === 1'b1) begin
          a = base + 10'(beats);
          check("st_data", bus.st_data, ram_val(a));
          check("st_last", bus.st_last, (beats == cnt - 1));
          if (first_beat < 0) first_beat = cyc;
          beats++;
          if (beats == cnt) last_seen = 1'b1;
          if (abort_beat != 0 && beats == abort_beat) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            check("abort_valid", bus.st_valid, 1'b0);
            check("abort_busy", bus.busy, 1'b0);
            repeat (6) begin
              if (bus.done === 1'b1) spurious++;
              if (bus.m_chipselect === 1'b1) post_abort_cs++;
              @(negedge clk);
            end
            check("abort_no_cs", post_abort_cs, 0);
            finished = 1'b1;
          end
        end
        if (!finished) begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    check("xfer_finished", finished, 1'b1);
    check("spurious_done", spurious, 0);
    if (abort_beat == 0) begin
      check("beat_count", beats, cnt);
      check("reads_issued", issued, cnt);
    end
    if (mode == 0 && abort_beat == 0) begin
      check("first_beat_latency", first_beat, 2);
      check("back_to_back_reads", last_cs - first_cs, cnt - 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    bus.st_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_cs", bus.m_chipselect, 1'b0);
    check("rst_valid", bus.st_valid, 1'b0);
    check("rst_last", bus.st_last, 1'b0);
    check("rst_addr", bus.m_address, 10'h000);
    check("m_write", bus.m_write, 1'b0);
    check("m_byteenable", bus.m_byteenable, 4'hF);
    check("m_clken", bus.m_clken, 1'b1);
    reset = 1'b0;

    run_xfer(10'h010, 4, 0, 0);
    run_xfer(10'h3FE, 4, 0, 0);
    run_xfer(10'h100, 16, 2, 0);
    run_xfer(10'h155, 1024, 1, 0);
    run_xfer(10'h200, 10, 0, 3);
    run_xfer(10'h020, 2, 0, 0);

    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 10'h030; bus.word_count = 11'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("zero_done", bus.done, 1'b1);
    check("zero_busy", bus.busy, 1'b0);
    check("zero_cs", bus.m_chipselect, 1'b0);
    @(negedge clk);
    check("zero_done_once", bus.done, 1'b0);
    check("zero_cs_after", bus.m_chipselect, 1'b0);

    bus.st_ready = 1'b0;
    bus.start = 1'b1; bus.base_addr = 10'h050; bus.word_count = 11'd16;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_valid", bus.st_valid, 1'b1);
    check("pre_reset_busy", bus.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", bus.busy, 1'b0);
    check("async_rst_cs", bus.m_chipselect, 1'b0);
    check("async_rst_valid", bus.st_valid, 1'b0);
    check("async_rst_last", bus.st_last, 1'b0);
    check("async_rst_addr", bus.m_address, 10'h000);
    check("async_rst_done", bus.done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.st_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", bus.st_valid, 1'b0);
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_cs", bus.m_chipselect, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
